// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// uart_rx_pkg: shared types and constants for the UART receive frame controller.
// Rev 1.0
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// uart_rx_bit_sampler: 3-point majority voter around the bit centre.
// Rev 1.0
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_in_i,
  input  logic [PRESC_W-1:0] edge_count_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               rx_bit_o,
  output logic               bit_vld_o
);

  localparam logic [PRESC_W-1:0] C_ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] C_TWO = PRESC_W'(2);

  logic [PRESC_W-1:0] w_half;
  logic [2:0]         samples_q;
  logic [2:0]         samples_d;

  assign w_half = prescale_i >> 1;

  always_comb begin
    samples_d = samples_q;
    if (edge_count_i == (w_half - C_ONE)) samples_d[0] = rx_in_i;
    if (edge_count_i == w_half)           samples_d[1] = rx_in_i;
    if (edge_count_i == (w_half + C_ONE)) samples_d[2] = rx_in_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      samples_q <= 3'b000;
    end else begin
      samples_q <= samples_d;
    end
  end

  // All three captures are registered by the time the count reaches H+2.
  assign rx_bit_o  = majority3(samples_q);
  assign bit_vld_o = (edge_count_i == (w_half + C_TWO));

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// uart_rx_fsm: UART receive frame controller (start detect, deserialize, parity/stop check).
// Rev 1.0
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic [PRESC_W-1:0]    EDGE_COUNT,
  input  logic [3:0]            BIT_COUNT,
  output logic                  COUNTER_EN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH + 1);

  rx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  cfg_par_en_q;
  logic                  cfg_par_typ_q;
  logic                  counter_en_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;
  logic                  busy_q;

  logic                  w_bit;
  logic                  w_bit_vld;
  logic                  w_bit_end;
  logic                  w_par_bad;

  uart_rx_bit_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk_i        (CLK),
    .rst_i        (RST),
    .rx_in_i      (RX_IN),
    .edge_count_i (EDGE_COUNT),
    .prescale_i   (PRESCALE),
    .rx_bit_o     (w_bit),
    .bit_vld_o    (w_bit_vld)
  );

  assign w_bit_end = (EDGE_COUNT == PRESCALE);
  assign shift_d   = {w_bit, shift_q[DATA_WIDTH-1:1]};
  assign w_par_bad = ((^shift_q) ^ cfg_par_typ_q) != w_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      p_data_q      <= '0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_typ_q <= 1'b0;
      counter_en_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!RX_IN) begin
            state_q       <= ST_START;
            cfg_par_en_q  <= PAR_EN;
            cfg_par_typ_q <= PAR_TYP;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            counter_en_q  <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_vld && w_bit) begin
            state_q      <= ST_IDLE;
            counter_en_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (w_bit_end) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_vld) begin
            shift_q <= shift_d;
          end
          if (w_bit_end && (BIT_COUNT == LAST_DATA_BIT)) begin
            state_q <= cfg_par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_bit_vld) begin
            par_err_q <= w_par_bad;
          end
          if (w_bit_end) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is seen from IDLE.
          if (w_bit_vld) begin
            stp_err_q <= ~w_bit;
            if (w_bit && !par_err_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end
            state_q      <= ST_IDLE;
            counter_en_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          counter_en_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign COUNTER_EN = counter_en_q;
  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign BUSY       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_rx_fsm: directed frames with an edge/bit counter model and a DATA_VALID scoreboard.
// Rev 1.0
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          CLK      = 1'b0;
  logic          RST      = 1'b0;
  logic          RX_IN    = 1'b1;
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic [PW-1:0] PRESCALE = PW'(PRESCALE_8);
  logic [PW-1:0] EDGE_COUNT;
  logic [3:0]    BIT_COUNT;
  logic          COUNTER_EN;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          BUSY;

  int            vectors     = 0;
  int            miscompares = 0;
  int            dv_count    = 0;
  logic [DW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  // Companion edge/bit counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      EDGE_COUNT <= '0;
      BIT_COUNT  <= 4'd1;
    end else if (!COUNTER_EN) begin
      EDGE_COUNT <= '0;
      BIT_COUNT  <= 4'd1;
    end else if (EDGE_COUNT == PRESCALE) begin
      EDGE_COUNT <= PW'(1);
      BIT_COUNT  <= BIT_COUNT + 4'd1;
    end else begin
      EDGE_COUNT <= EDGE_COUNT + PW'(1);
    end
  end

  uart_rx_fsm #(
    .DATA_WIDTH (DW),
    .PRESC_W    (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .EDGE_COUNT (EDGE_COUNT),
    .BIT_COUNT  (BIT_COUNT),
    .COUNTER_EN (COUNTER_EN),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .BUSY       (BUSY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DATA_VALID pulse must match the oldest expected frame.
  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_dv: got P_DATA 0x%0h, expected no DATA_VALID", P_DATA);
      end else begin
        check("dv_data", 32'(P_DATA), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive_bit(input logic v);
    RX_IN = v;
    repeat (int'(PRESCALE)) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par_on,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (par_on) drive_bit(par_bit);
    drive_bit(stop_bit);
    RX_IN = 1'b1;
  endtask

  // Idle line for n cycles, then park on the falling edge for checks.
  task automatic settle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic realign();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_cnt_en", 32'(COUNTER_EN), 0);
    check("rst_dv", 32'(DATA_VALID), 0);
    check("rst_flags", {30'd0, PAR_ERR, STP_ERR}, 0);
    check("rst_p_data", 32'(P_DATA), 0);
    realign();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    // 1: PRESCALE 8, even parity, 0xA5 (parity bit 0)
    PRESCALE = PW'(PRESCALE_8);
    PAR_EN   = 1'b1;
    PAR_TYP  = PAR_EVEN;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    settle(4);
    check("t1_par_err", 32'(PAR_ERR), 0);
    check("t1_stp_err", 32'(STP_ERR), 0);
    check("t1_p_data", 32'(P_DATA), 32'h A5);
    check("t1_pending", 32'(exp_q.size()), 0);
    realign();

    // 2: PRESCALE 16, odd parity, 0x3C with wrong parity bit 0
    PRESCALE = PW'(PRESCALE_16);
    PAR_TYP  = PAR_ODD;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    settle(4);
    check("t2_par_err", 32'(PAR_ERR), 1);
    check("t2_stp_err", 32'(STP_ERR), 0);
    check("t2_p_data", 32'(P_DATA), 32'h A5);
    check("t2_busy", 32'(BUSY), 0);
    realign();

    // 3: PRESCALE 8, no parity, 0x81 with stop 0, then good 0x7E
    PRESCALE = PW'(PRESCALE_8);
    PAR_EN   = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    settle(4);
    check("t3_stp_err", 32'(STP_ERR), 1);
    check("t3_par_err", 32'(PAR_ERR), 0);
    check("t3_p_data", 32'(P_DATA), 32'h A5);
    realign();
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t3b_stp_err", 32'(STP_ERR), 0);
    check("t3b_p_data", 32'(P_DATA), 32'h 7E);
    check("t3b_pending", 32'(exp_q.size()), 0);
    realign();

    // 4: start glitch, RX_IN low for 2 cycles
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    @(negedge CLK);
    check("t4_busy_hi", 32'(BUSY), 1);
    check("t4_cnt_en_hi", 32'(COUNTER_EN), 1);
    settle(10);
    check("t4_busy_lo", 32'(BUSY), 0);
    check("t4_cnt_en_lo", 32'(COUNTER_EN), 0);
    check("t4_flags", {30'd0, PAR_ERR, STP_ERR}, 0);
    check("t4_p_data", 32'(P_DATA), 32'h 7E);
    realign();

    // 5: PRESCALE 16, no parity, 0x55 and 0xAA back-to-back
    PRESCALE = PW'(PRESCALE_16);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t5_pending", 32'(exp_q.size()), 0);
    check("t5_p_data", 32'(P_DATA), 32'h AA);
    check("t5_flags", {30'd0, PAR_ERR, STP_ERR}, 0);
    realign();

    // 6: reset during data of 0xF0, then 0x0F
    PRESCALE = PW'(PRESCALE_8);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    RST = 1'b0;
    RX_IN = 1'b1;
    @(negedge CLK);
    check("t6_rst_busy", 32'(BUSY), 0);
    check("t6_rst_cnt_en", 32'(COUNTER_EN), 0);
    check("t6_rst_p_data", 32'(P_DATA), 0);
    realign();
    realign();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    settle(4);
    check("t6_p_data", 32'(P_DATA), 32'h 0F);
    check("t6_pending", 32'(exp_q.size()), 0);

    settle(8);
    check("dv_total", 32'(dv_count), 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
